sha_sigma_pipe: RTL

Parametrised, pipelined SHA-2 sigma unit computing any of the four SHA-2 sigma functions (Σ0, Σ1, σ0, σ1) on a selectable word width. It replaces the single-function, combinational Σ1 block inside the message-schedule and compression datapath. It adds mode selection, a valid/ready handshake with backpressure, per-stage registering and a tag pass-through. The scheduler and round engine share one instance.

---
 rtl/sha_sigma_pipe.sv | 155 +++++++++++++++
 1 files changed

// File: rtl/sha_sigma_pipe.sv
// Pipelined SHA-2 sigma unit (Σ0/Σ1/σ0/σ1, 32- or 64-bit) with valid/ready flow control and tag pass-through.
// Optional build macro: SHA_SIGMA_ZERO_IDLE_EN forces out_data/out_tag to zero while out_valid is low.
module sha_sigma_pipe #(
    parameter int WORD_W      = 32,
    parameter int PIPE_STAGES = 2,
    parameter int TAG_W       = 6
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [1:0]        in_mode,
    input  logic [WORD_W-1:0] in_data,
    input  logic [TAG_W-1:0]  in_tag,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [WORD_W-1:0] out_data,
    output logic [TAG_W-1:0]  out_tag
);

    localparam bit W64 = (WORD_W == 64);

    localparam int unsigned BS0_A = W64 ? 28 : 2;
    localparam int unsigned BS0_B = W64 ? 34 : 13;
    localparam int unsigned BS0_C = W64 ? 39 : 22;
    localparam int unsigned BS1_A = W64 ? 14 : 6;
    localparam int unsigned BS1_B = W64 ? 18 : 11;
    localparam int unsigned BS1_C = W64 ? 41 : 25;
    localparam int unsigned SS0_A = W64 ? 1  : 7;
    localparam int unsigned SS0_B = W64 ? 8  : 18;
    localparam int unsigned SS0_C = W64 ? 7  : 3;
    localparam int unsigned SS1_A = W64 ? 19 : 17;
    localparam int unsigned SS1_B = W64 ? 61 : 19;
    localparam int unsigned SS1_C = W64 ? 6  : 10;

    if (WORD_W != 32 && WORD_W != 64) begin : g_bad_word_w
        $error("sha_sigma_pipe: WORD_W must be 32 or 64");
    end
    if (PIPE_STAGES != 1 && PIPE_STAGES != 2) begin : g_bad_stages
        $error("sha_sigma_pipe: PIPE_STAGES must be 1 or 2");
    end

    function automatic logic [WORD_W-1:0] rotr(input logic [WORD_W-1:0] x, input int unsigned n);
        return (x >> n) | (x << (WORD_W - n));
    endfunction

    logic [WORD_W-1:0] term_a, term_b, term_c;

    // Third term is a rotate for the big sigmas and a zero-fill shift for the small ones.
    always_comb begin
        term_a = '0;
        term_b = '0;
        term_c = '0;
        case (in_mode)
            2'b00: begin
                term_a = rotr(in_data, BS0_A);
                term_b = rotr(in_data, BS0_B);
                term_c = rotr(in_data, BS0_C);
            end
            2'b01: begin
                term_a = rotr(in_data, BS1_A);
                term_b = rotr(in_data, BS1_B);
                term_c = rotr(in_data, BS1_C);
            end
            2'b10: begin
                term_a = rotr(in_data, SS0_A);
                term_b = rotr(in_data, SS0_B);
                term_c = in_data >> SS0_C;
            end
            default: begin
                term_a = rotr(in_data, SS1_A);
                term_b = rotr(in_data, SS1_B);
                term_c = in_data >> SS1_C;
            end
        endcase
    end

    logic              st_valid;
    logic [WORD_W-1:0] st_data;
    logic [TAG_W-1:0]  st_tag;
    logic              first_load;

    if (PIPE_STAGES == 1) begin : g_one_stage
        logic last_load;

        assign last_load  = !st_valid || out_ready;
        assign first_load = last_load;

        always_ff @(posedge clk) begin
            if (!rst_n) begin
                st_valid <= 1'b0;
                st_data  <= '0;
                st_tag   <= '0;
            end else if (last_load) begin
                st_valid <= in_valid;
                if (in_valid) begin
                    st_data <= term_a ^ term_b ^ term_c;
                    st_tag  <= in_tag;
                end
            end
        end
    end else begin : g_two_stage
        logic              s1_valid;
        logic [WORD_W-1:0] s1_a, s1_b, s1_c;
        logic [TAG_W-1:0]  s1_tag;
        logic              s1_load, s2_load;

        // A stage may load when empty or when its occupant leaves on the same edge.
        assign s2_load    = !st_valid || out_ready;
        assign s1_load    = !s1_valid || s2_load;
        assign first_load = s1_load;

        always_ff @(posedge clk) begin
            if (!rst_n) begin
                s1_valid <= 1'b0;
                s1_a     <= '0;
                s1_b     <= '0;
                s1_c     <= '0;
                s1_tag   <= '0;
                st_valid <= 1'b0;
                st_data  <= '0;
                st_tag   <= '0;
            end else begin
                if (s2_load) begin
                    st_valid <= s1_valid;
                    if (s1_valid) begin
                        st_data <= s1_a ^ s1_b ^ s1_c;
                        st_tag  <= s1_tag;
                    end
                end
                if (s1_load) begin
                    s1_valid <= in_valid;
                    if (in_valid) begin
                        s1_a   <= term_a;
                        s1_b   <= term_b;
                        s1_c   <= term_c;
                        s1_tag <= in_tag;
                    end
                end
            end
        end
    end

    assign in_ready  = rst_n && first_load;
    assign out_valid = st_valid;

`ifdef SHA_SIGMA_ZERO_IDLE_EN
    assign out_data = st_valid ? st_data : '0;
    assign out_tag  = st_valid ? st_tag  : '0;
`else
    assign out_data = st_data;
    assign out_tag  = st_tag;
`endif

endmodule
